// File: rtl/double_threshold_unit.sv
// Frame-based double-threshold classifier: finds the frame maximum, derives high/low thresholds
// from it, then maps each pixel to STRONG_PIXEL, WEAK_PIXEL or 0 for the hysteresis stage.
module double_threshold_unit #(
  parameter int unsigned HEIGHT       = 5,
  parameter int unsigned WIDTH        = 5,
  parameter logic [7:0]  HIGH_RATIO   = 8'd128,
  parameter logic [7:0]  LOW_RATIO    = 8'd128,
  parameter logic [7:0]  WEAK_PIXEL   = 8'd75,
  parameter logic [7:0]  STRONG_PIXEL = 8'd255,
  localparam int unsigned IMG_SIZE    = HEIGHT * WIDTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] img [0:IMG_SIZE-1],
  output logic [7:0] res [0:IMG_SIZE-1],
  output logic       done
);

  localparam int unsigned     IdxW    = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(IMG_SIZE - 1);

  typedef enum logic [2:0] {StIdle, StFindMax, StCalcThr, StClassify, StDone} state_e;

  state_e          state_q, state_d;
  logic [7:0]      frame_q [IMG_SIZE];
  logic [7:0]      res_q   [IMG_SIZE];
  logic [IdxW-1:0] idx_q;
  logic [7:0]      max_q, high_q, low_q;
  logic            done_q;

  logic            load, max_step, thr_step, class_step, last_idx;
  logic [7:0]      pixel, high_d, low_d, class_val;

  assign pixel    = frame_q[idx_q];
  assign last_idx = (idx_q == LastIdx);

  // Low threshold is derived from the freshly computed high threshold, not the stale register.
  always_comb begin
    high_d = 8'((16'(max_q) * 16'(HIGH_RATIO)) >> 8);
    low_d  = 8'((16'(high_d) * 16'(LOW_RATIO)) >> 8);
  end

  // Zero pixels stay zero even when both thresholds collapse to 0.
  always_comb begin
    class_val = 8'd0;
    if (pixel == 8'd0) begin
      class_val = 8'd0;
    end else if (pixel >= high_q) begin
      class_val = STRONG_PIXEL;
    end else if (pixel >= low_q) begin
      class_val = WEAK_PIXEL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (enable) state_d = StFindMax;
      StFindMax:      if (last_idx) state_d = StCalcThr;
      StCalcThr:      state_d = StClassify;
      StClassify:     if (last_idx) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    load       = 1'b0;
    max_step   = 1'b0;
    thr_step   = 1'b0;
    class_step = 1'b0;
    unique case (state_q)
      StIdle, StDone: load       = enable;
      StFindMax:      max_step   = 1'b1;
      StCalcThr:      thr_step   = 1'b1;
      StClassify:     class_step = 1'b1;
      default:        ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < IMG_SIZE; i++) begin
        frame_q[i] <= 8'd0;
        res_q[i]   <= 8'd0;
      end
      idx_q  <= '0;
      max_q  <= 8'd0;
      high_q <= 8'd0;
      low_q  <= 8'd0;
      done_q <= 1'b0;
    end else begin
      if (load) begin
        for (int i = 0; i < IMG_SIZE; i++) frame_q[i] <= img[i];
        idx_q  <= '0;
        max_q  <= 8'd0;
        done_q <= 1'b0;
      end
      if (max_step) begin
        if (pixel > max_q) max_q <= pixel;
        idx_q <= last_idx ? '0 : idx_q + 1'b1;
      end
      if (thr_step) begin
        high_q <= high_d;
        low_q  <= low_d;
        idx_q  <= '0;
      end
      if (class_step) begin
        res_q[idx_q] <= class_val;
        if (last_idx) begin
          done_q <= 1'b1;
          idx_q  <= '0;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  assign res  = res_q;
  assign done = done_q;

endmodule

// File: tb/tb_double_threshold_unit.sv
// Randomized and directed bench for double_threshold_unit against an arithmetic reference model.
module tb_double_threshold_unit;

  localparam int N       = 25;
  localparam int Latency = 51;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] img [0:N-1];
  logic [7:0] res [0:N-1];
  logic       done;

  int n_vec = 0;
  int n_err = 0;
  int stim    [N];
  int exp_res [N];

  always #5 clk = ~clk;

  double_threshold_unit dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .img    (img),
    .res    (res),
    .done   (done)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input int exp);
    n_vec++;
    if (obs !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: thresholds as integer fractions of the maximum, then the three-way rule.
  function automatic void model();
    int mx = 0;
    int hi, lo;
    foreach (stim[i]) if (stim[i] > mx) mx = stim[i];
    hi = (mx * 128) / 256;
    lo = (hi * 128) / 256;
    foreach (stim[i]) begin
      if (stim[i] == 0)       exp_res[i] = 0;
      else if (stim[i] >= hi) exp_res[i] = 255;
      else if (stim[i] >= lo) exp_res[i] = 75;
      else                    exp_res[i] = 0;
    end
  endfunction

  function automatic int count_nonzero();
    int c = 0;
    for (int i = 0; i < N; i++) if (res[i] !== 8'd0) c++;
    return c;
  endfunction

  function automatic void clear_stim();
    foreach (stim[i]) stim[i] = 0;
  endfunction

  function automatic void set_s2();
    clear_stim();
    stim[6] = 200; stim[11] = 120; stim[12] = 60; stim[13] = 40;
  endfunction

  task automatic run_frame(input string tag, input bit noisy);
    int cnt;
    model();
    @(negedge clk);
    for (int i = 0; i < N; i++) img[i] = 8'(stim[i]);
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    check_val({tag, "/done_drop"}, 32'(done), 0);
    // The frame was captured at the enable edge; later input changes must not matter.
    if (noisy) for (int i = 0; i < N; i++) img[i] = 8'($urandom);
    cnt = 0;
    while (done !== 1'b1 && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
      enable = (noisy && cnt < Latency - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    enable = 1'b0;
    check_val({tag, "/latency"}, 32'(cnt), Latency);
    for (int i = 0; i < N; i++) check_val($sformatf("%s/res[%0d]", tag, i), 32'(res[i]), exp_res[i]);
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    for (int i = 0; i < N; i++) img[i] = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check_val("rst/done", 32'(done), 0);
      check_val("rst/res_nonzero", 32'(count_nonzero()), 0);
    end

    set_s2();
    run_frame("s2", 1'b0);
    check_val("s2/res6", 32'(res[6]), 255);
    check_val("s2/res11", 32'(res[11]), 255);
    check_val("s2/res12", 32'(res[12]), 75);
    check_val("s2/res13", 32'(res[13]), 0);

    clear_stim();
    stim[0] = 200; stim[1] = 100; stim[2] = 50; stim[3] = 49;
    run_frame("s3_bound", 1'b0);
    check_val("s3/100", 32'(res[1]), 255);
    check_val("s3/50", 32'(res[2]), 75);
    check_val("s3/49", 32'(res[3]), 0);

    clear_stim();
    stim[24] = 1;
    run_frame("s3_max1", 1'b0);
    check_val("s3/max1", 32'(res[24]), 255);

    clear_stim();
    run_frame("s4_zero", 1'b0);
    check_val("s4/nonzero", 32'(count_nonzero()), 0);

    set_s2();
    run_frame("s5_toggle", 1'b1);
    set_s2();
    stim[0] = 90;
    run_frame("s5_again", 1'b0);

    // Reset pulse mid-FIND_MAX, away from any clock edge.
    set_s2();
    @(negedge clk);
    for (int i = 0; i < N; i++) img[i] = 8'(stim[i]);
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_val("s6/done_async", 32'(done), 0);
    check_val("s6/res_nonzero", 32'(count_nonzero()), 0);
    @(negedge clk);
    reset = 1'b0;
    set_s2();
    run_frame("s6_after", 1'b0);

    for (int f = 0; f < 8; f++) begin
      int lim;
      case ($urandom_range(0, 2))
        0:       lim = 255;
        1:       lim = 15;
        default: lim = 3;
      endcase
      foreach (stim[i]) stim[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, lim));
      run_frame($sformatf("rand%0d", f), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
